// File: rtl/frame_burst_scheduler.sv
// Round-robin burst scheduler: picks an eligible frame-buffer port, issues one AXI
// burst command at a time and advances that port's frame offset on completion.
module frame_burst_scheduler #(
   parameter int                   NUM_PORTS    = 3,
   parameter logic [NUM_PORTS-1:0] PORT_IS_RD   = 3'b100,
   parameter logic [31:0]          BASE_ADDR    = 32'h1000_0000,
   parameter logic [31:0]          REGION_BYTES = 32'h0080_0000,
   parameter int                   ADDR_WIDTH   = 32,
   parameter int                   DATA_WIDTH   = 128,
   parameter int                   BURST_LEN    = 16,
   parameter int                   FRAME_BEATS  = 172800,
   parameter int                   LEVEL_W      = 10,
   localparam int                  PORT_W       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                         M_AXI_ACLK,
   input  logic                         M_AXI_ARESET,
   input  logic [NUM_PORTS-1:0]         port_frame_start,
   input  logic [NUM_PORTS*LEVEL_W-1:0] port_level,
   output logic                         cmd_valid,
   input  logic                         cmd_ready,
   output logic                         cmd_rd,
   output logic [ADDR_WIDTH-1:0]        cmd_addr,
   output logic [7:0]                   cmd_len,
   output logic [PORT_W-1:0]            cmd_port,
   input  logic                         cmd_done,
   output logic [NUM_PORTS-1:0]         port_grant,
   output logic [NUM_PORTS-1:0]         port_frame_done,
   output logic                         busy
);

   localparam int                OFF_W      = $clog2(FRAME_BEATS + 1);
   localparam int                BEAT_BYTES = DATA_WIDTH / 8;
   localparam logic [1:0]        ST_ARB     = 2'd0;
   localparam logic [1:0]        ST_ISSUE   = 2'd1;
   localparam logic [1:0]        ST_WAIT    = 2'd2;
   localparam logic [LEVEL_W:0]  BURST_LVL  = (LEVEL_W + 1)'(BURST_LEN);
   localparam logic [OFF_W-1:0]  OFF_STEP   = OFF_W'(BURST_LEN);
   localparam logic [OFF_W-1:0]  OFF_END    = OFF_W'(FRAME_BEATS);
   localparam logic [PORT_W-1:0] LAST_INIT  = PORT_W'(NUM_PORTS - 1);

   logic [1:0]            state_q, state_d;
   logic                  cmd_valid_q, cmd_valid_d;
   logic                  cmd_rd_q, cmd_rd_d;
   logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [7:0]            cmd_len_q, cmd_len_d;
   logic [PORT_W-1:0]     cmd_port_q, cmd_port_d;
   logic [NUM_PORTS-1:0]  port_grant_q, port_grant_d;
   logic [NUM_PORTS-1:0]  frame_done_q, frame_done_d;
   logic [PORT_W-1:0]     last_grant_q, last_grant_d;
   logic                  discard_q, discard_d;
   logic [OFF_W-1:0]      offset_q [NUM_PORTS];
   logic [OFF_W-1:0]      offset_d [NUM_PORTS];

   logic [NUM_PORTS-1:0]  eligible;
   logic                  found;
   logic [PORT_W-1:0]     sel_port;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [OFF_W-1:0]      next_off;
   int                    search_idx;

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         eligible[p] = ({1'b0, port_level[p*LEVEL_W +: LEVEL_W]} >= BURST_LVL) && !frame_done_q[p];
      end
   end

   // Round-robin search starting just after the last completed port.
   always_comb begin
      found      = 1'b0;
      sel_port   = '0;
      search_idx = 0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         search_idx = int'(last_grant_q) + i;
         if (search_idx >= NUM_PORTS) search_idx = search_idx - NUM_PORTS;
         if (!found && eligible[PORT_W'(search_idx)]) begin
            found    = 1'b1;
            sel_port = PORT_W'(search_idx);
         end
      end
   end

   assign sel_addr = ADDR_WIDTH'(BASE_ADDR)
                   + ADDR_WIDTH'(sel_port) * ADDR_WIDTH'(REGION_BYTES)
                   + ADDR_WIDTH'(offset_q[sel_port]) * ADDR_WIDTH'(BEAT_BYTES);

   assign next_off = offset_q[cmd_port_q] + OFF_STEP;

   always_comb begin
      state_d      = state_q;
      cmd_valid_d  = cmd_valid_q;
      cmd_rd_d     = cmd_rd_q;
      cmd_addr_d   = cmd_addr_q;
      cmd_len_d    = cmd_len_q;
      cmd_port_d   = cmd_port_q;
      port_grant_d = port_grant_q;
      frame_done_d = frame_done_q;
      last_grant_d = last_grant_q;
      discard_d    = discard_q;
      for (int p = 0; p < NUM_PORTS; p++) offset_d[p] = offset_q[p];

      // discard_q remembers a frame restart on the in-flight port so its completion
      // does not advance the freshly cleared offset.
      case (state_q)
         ST_ARB: begin
            if (found) begin
               cmd_valid_d = 1'b1;
               cmd_port_d  = sel_port;
               cmd_addr_d  = sel_addr;
               cmd_rd_d    = PORT_IS_RD[sel_port];
               cmd_len_d   = 8'(BURST_LEN - 1);
               discard_d   = port_frame_start[sel_port];
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (port_frame_start[cmd_port_q]) discard_d = 1'b1;
            if (cmd_ready) begin
               cmd_valid_d  = 1'b0;
               port_grant_d = NUM_PORTS'(1) << cmd_port_q;
               state_d      = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cmd_done) begin
               if (!discard_q && !port_frame_start[cmd_port_q]) begin
                  offset_d[cmd_port_q] = next_off;
                  if (next_off == OFF_END) frame_done_d[cmd_port_q] = 1'b1;
               end
               last_grant_d = cmd_port_q;
               port_grant_d = '0;
               discard_d    = 1'b0;
               state_d      = ST_ARB;
            end else if (port_frame_start[cmd_port_q]) begin
               discard_d = 1'b1;
            end
         end
         default: state_d = ST_ARB;
      endcase

      for (int p = 0; p < NUM_PORTS; p++) begin
         if (port_frame_start[p]) begin
            offset_d[p]     = '0;
            frame_done_d[p] = 1'b0;
         end
      end
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (M_AXI_ARESET) begin
         state_q      <= ST_ARB;
         cmd_valid_q  <= 1'b0;
         cmd_rd_q     <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_len_q    <= '0;
         cmd_port_q   <= '0;
         port_grant_q <= '0;
         frame_done_q <= '0;
         last_grant_q <= LAST_INIT;
         discard_q    <= 1'b0;
         for (int p = 0; p < NUM_PORTS; p++) offset_q[p] <= '0;
      end else begin
         state_q      <= state_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_rd_q     <= cmd_rd_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_len_q    <= cmd_len_d;
         cmd_port_q   <= cmd_port_d;
         port_grant_q <= port_grant_d;
         frame_done_q <= frame_done_d;
         last_grant_q <= last_grant_d;
         discard_q    <= discard_d;
         for (int p = 0; p < NUM_PORTS; p++) offset_q[p] <= offset_d[p];
      end
   end

   assign cmd_valid       = cmd_valid_q;
   assign cmd_rd          = cmd_rd_q;
   assign cmd_addr        = cmd_addr_q;
   assign cmd_len         = cmd_len_q;
   assign cmd_port        = cmd_port_q;
   assign port_grant      = port_grant_q;
   assign port_frame_done = frame_done_q;
   assign busy            = (state_q != ST_ARB);

endmodule

// File: tb/tb_frame_burst_scheduler.sv
// Self-checking bench for frame_burst_scheduler: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a burst-level model.
module tb_frame_burst_scheduler;

   localparam int NP = 3;
   localparam int BL = 16;
   localparam int FB = 64;
   localparam logic [2:0] IS_RD = 3'b100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  port_frame_start = '0;
   logic [9:0]  lvl [NP];
   logic [29:0] port_level;
   logic        cmd_valid, cmd_ready, cmd_rd, cmd_done;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [1:0]  cmd_port;
   logic [2:0]  port_grant, port_frame_done;
   logic        busy;

   int checks = 0;
   int errors = 0;

   assign port_level = {lvl[2], lvl[1], lvl[0]};

   always #5 clk = ~clk;

   frame_burst_scheduler #(
      .NUM_PORTS(NP), .PORT_IS_RD(IS_RD), .BASE_ADDR(32'h1000_0000),
      .REGION_BYTES(32'h0080_0000), .ADDR_WIDTH(32), .DATA_WIDTH(128),
      .BURST_LEN(BL), .FRAME_BEATS(FB), .LEVEL_W(10)
   ) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(rst), .port_frame_start(port_frame_start),
      .port_level(port_level), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_port(cmd_port),
      .cmd_done(cmd_done), .port_grant(port_grant), .port_frame_done(port_frame_done),
      .busy(busy)
   );

   // Model: a pending command, an outstanding burst and per-port beat offsets.
   bit          m_live = 0;
   bit          m_valid, m_active, m_discard, m_rd;
   int          m_port, m_last;
   logic [31:0] m_addr;
   int          off [NP];
   bit [2:0]    m_done, m_grant;

   task automatic modelStep();
      int p;
      if (rst) begin
         m_live = 1; m_valid = 0; m_active = 0; m_discard = 0; m_rd = 0;
         m_port = 0; m_last = NP - 1; m_addr = '0; m_done = '0; m_grant = '0;
         for (int k = 0; k < NP; k++) off[k] = 0;
      end else begin
         if (!m_valid && !m_active) begin
            for (int k = 1; k <= NP; k++) begin
               p = (m_last + k) % NP;
               if (!m_valid && int'(lvl[p]) >= BL && !m_done[p]) begin
                  m_valid   = 1;
                  m_port    = p;
                  m_rd      = IS_RD[p];
                  m_addr    = 32'h1000_0000 + 32'(p) * 32'h0080_0000 + 32'(off[p] * 16);
                  m_discard = port_frame_start[p];
               end
            end
         end else if (m_valid) begin
            if (port_frame_start[m_port]) m_discard = 1;
            if (cmd_ready) begin
               m_valid  = 0;
               m_active = 1;
               m_grant  = 3'(1 << m_port);
            end
         end else if (cmd_done) begin
            if (!m_discard && !port_frame_start[m_port]) begin
               off[m_port] = off[m_port] + BL;
               if (off[m_port] == FB) m_done[m_port] = 1;
            end
            m_last = m_port; m_grant = '0; m_active = 0; m_discard = 0;
         end else if (port_frame_start[m_port]) begin
            m_discard = 1;
         end
         for (int k = 0; k < NP; k++) begin
            if (port_frame_start[k]) begin off[k] = 0; m_done[k] = 0; end
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      modelStep();
   end

   initial forever begin
      @(negedge clk);
      if (m_live) begin
         checkOutput("cyc cmd_valid", cmd_valid, m_valid);
         checkOutput("cyc port_grant", port_grant, m_grant);
         checkOutput("cyc frame_done", port_frame_done, m_done);
         checkOutput("cyc busy", busy, m_valid || m_active);
         if (m_valid) begin
            checkOutput("cyc cmd_addr", cmd_addr, m_addr);
            checkOutput("cyc cmd_port", cmd_port, m_port);
            checkOutput("cyc cmd_rd", cmd_rd, m_rd);
            checkOutput("cyc cmd_len", cmd_len, 15);
         end
      end
   end

   task automatic applyReset();
      rst = 1; cmd_ready = 0; cmd_done = 0; port_frame_start = '0;
      for (int k = 0; k < NP; k++) lvl[k] = '0;
      tick();
      checkOutput("rst cmd_valid", cmd_valid, 0);
      checkOutput("rst cmd_addr", cmd_addr, 0);
      checkOutput("rst cmd_port", cmd_port, 0);
      checkOutput("rst cmd_rd", cmd_rd, 0);
      checkOutput("rst cmd_len", cmd_len, 0);
      checkOutput("rst port_grant", port_grant, 0);
      checkOutput("rst frame_done", port_frame_done, 0);
      checkOutput("rst busy", busy, 0);
      rst = 0;
   endtask

   task automatic waitValid(input string tag);
      int n = 0;
      while (cmd_valid !== 1'b1 && n < 40) begin tick(); n++; end
      checkOutput({tag, " valid"}, cmd_valid, 1);
   endtask

   // fsMode 1 restarts the port's frame during WAIT, 2 on the cmd_done cycle.
   task automatic applyStimulus(input string tag, input int expPort, input logic [31:0] expAddr,
                                input bit expRd, input int fsMode);
      waitValid(tag);
      checkOutput({tag, " port"}, cmd_port, expPort);
      checkOutput({tag, " addr"}, cmd_addr, expAddr);
      checkOutput({tag, " rd"}, cmd_rd, expRd);
      checkOutput({tag, " len"}, cmd_len, 15);
      cmd_ready = 1; tick(); cmd_ready = 0;
      checkOutput({tag, " grant"}, port_grant, 1 << expPort);
      tick();
      if (fsMode == 1) port_frame_start[expPort] = 1;
      tick();
      port_frame_start = '0;
      tick();
      if (fsMode == 2) port_frame_start[expPort] = 1;
      cmd_done = 1; tick(); cmd_done = 0; port_frame_start = '0;
      checkOutput({tag, " grant off"}, port_grant, 0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      cmd_ready = 0; cmd_done = 0;
      for (int k = 0; k < NP; k++) lvl[k] = '0;

      applyReset();
      lvl[0] = 16;
      applyStimulus("t1a", 0, 32'h1000_0000, 0, 0);
      checkOutput("t1 gap0 valid", cmd_valid, 0);
      tick();
      checkOutput("t1 gap1 valid", cmd_valid, 1);
      applyStimulus("t1b", 0, 32'h1000_0100, 0, 0);

      applyReset();
      for (int k = 0; k < NP; k++) lvl[k] = 20;
      applyStimulus("t2a", 0, 32'h1000_0000, 0, 0);
      applyStimulus("t2b", 1, 32'h1080_0000, 0, 0);
      applyStimulus("t2c", 2, 32'h1100_0000, 1, 0);
      applyStimulus("t2d", 0, 32'h1000_0100, 0, 0);

      applyReset();
      lvl[0] = 16;
      waitValid("t3");
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("t3 hold valid", cmd_valid, 1);
         checkOutput("t3 hold addr", cmd_addr, 32'h1000_0000);
         checkOutput("t3 hold grant", port_grant, 0);
      end
      applyStimulus("t3", 0, 32'h1000_0000, 0, 0);

      applyReset();
      lvl[0] = 16;
      for (int k = 0; k < 4; k++) applyStimulus("t4", 0, 32'h1000_0000 + 32'(k * 256), 0, 0);
      checkOutput("t4 frame_done", port_frame_done, 3'b001);
      repeat (6) tick();
      checkOutput("t4 idle valid", cmd_valid, 0);
      checkOutput("t4 idle busy", busy, 0);
      port_frame_start = 3'b001; tick(); port_frame_start = '0;
      checkOutput("t4 done cleared", port_frame_done, 0);
      applyStimulus("t4 restart", 0, 32'h1000_0000, 0, 0);

      applyReset();
      lvl[0] = 16;
      applyStimulus("t5a", 0, 32'h1000_0000, 0, 0);
      applyStimulus("t5b", 0, 32'h1000_0100, 0, 1);
      applyStimulus("t5c", 0, 32'h1000_0000, 0, 0);
      applyStimulus("t5d", 0, 32'h1000_0100, 0, 2);
      applyStimulus("t5e", 0, 32'h1000_0000, 0, 0);

      applyReset();
      lvl[0] = 15;
      repeat (8) tick();
      checkOutput("t6 level15 valid", cmd_valid, 0);
      checkOutput("t6 level15 busy", busy, 0);
      lvl[0] = 16;
      applyStimulus("t6a", 0, 32'h1000_0000, 0, 0);
      lvl[0] = 0; lvl[1] = 16;
      waitValid("t6b");
      checkOutput("t6b port", cmd_port, 1);
      checkOutput("t6b addr", cmd_addr, 32'h1080_0000);
      cmd_ready = 1; tick(); cmd_ready = 0;
      checkOutput("t6b grant", port_grant, 3'b010);
      tick();
      applyReset();
      for (int k = 0; k < NP; k++) lvl[k] = 16;
      applyStimulus("t6c", 0, 32'h1000_0000, 0, 0);

      applyReset();
      for (int c = 0; c < 4000; c++) begin
         cmd_ready = ($urandom_range(0, 3) != 0);
         cmd_done  = m_active ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
         for (int k = 0; k < NP; k++) port_frame_start[k] = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 7) == 0) lvl[$urandom_range(0, NP - 1)] = 10'($urandom_range(12, 22));
         rst = ($urandom_range(0, 999) == 0);
         tick();
      end
      rst = 0; cmd_ready = 0; cmd_done = 0; port_frame_start = '0;
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/frame_burst_scheduler.md
Name: frame_burst_scheduler

Overview:
- Sequences and arbitrates AXI-full burst traffic between several frame-buffer ports, e.g. the cmos write paths and the video read path, all sharing the one AXI master and its memory.
- Per port it tracks the frame offset and decides when a burst is due. It round-robins between eligible ports and issues one burst command at a time to the AXI master engine.
- It sits between the port FIFOs and the AXI master inside the stitching top.

Parameters:
NUM_PORTS, 3, number of requesting ports
PORT_IS_RD, 3'b100, per-port direction bit (1 = read port, 0 = write port)
BASE_ADDR, 32'h1000_0000, base of the frame-buffer area
REGION_BYTES, 32'h0080_0000, address stride between port regions
ADDR_WIDTH, 32, command address width
DATA_WIDTH, 128, AXI data width; one beat = DATA_WIDTH/8 bytes
BURST_LEN, 16, beats per burst (1..256)
FRAME_BEATS, 172800, beats per frame; must be a multiple of BURST_LEN
LEVEL_W, 10, width of each port level

Ports:
M_AXI_ACLK  in  1  single clock for the whole block
M_AXI_ARESET  in  1  synchronous, active-high reset
port_frame_start  in  NUM_PORTS  per-port one-cycle pulse: new frame begins
port_level  in  NUM_PORTS*LEVEL_W  per-port FIFO beats available (write port) or free beats (read port)
cmd_valid  out  1  burst command valid
cmd_ready  in  1  AXI master accepts the command
cmd_rd  out  1  1 = read burst, 0 = write burst
cmd_addr  out  ADDR_WIDTH  burst start byte address
cmd_len  out  8  BURST_LEN-1
cmd_port  out  clog2(NUM_PORTS)  index of the granted port
cmd_done  in  1  one-cycle pulse from the master when the burst completes (BRESP or RLAST)
port_grant  out  NUM_PORTS  one-hot, selects the FIFO that is connected to the master
port_frame_done  out  NUM_PORTS  sticky per-port flag: whole frame transferred
busy  out  1  high whenever the FSM is not in ARB

Behaviour:
- Reset, synchronous and active-high:
  - all outputs go to 0;
  - every offset is cleared to 0 and every frame_done flag is cleared;
  - last_grant is set to NUM_PORTS-1, so port 0 has first priority;
  - the FSM goes to ARB.
  - A reset in the middle of a burst abandons it; the AXI master is reset by the same signal.
- Eligibility: port p is eligible when port_level[p] >= BURST_LEN and port_frame_done[p] = 0.
- Address: BASE_ADDR + p*REGION_BYTES + offset[p]*(DATA_WIDTH/8). Computed modulo 2^ADDR_WIDTH.
- Offset counter width is clog2(FRAME_BEATS+1).
- FSM states are ARB, ISSUE and WAIT.
- ARB:
  - Search for an eligible port starting at last_grant+1, wrapping modulo NUM_PORTS.
  - If one is found, register cmd_port, cmd_addr and cmd_rd (= PORT_IS_RD[p]), set cmd_valid = 1 and go to ISSUE.
  - cmd_valid therefore rises one cycle after eligibility is seen in ARB.
  - If none is found, stay in ARB.
- ISSUE:
  - Hold cmd_valid and every cmd_* field stable until cmd_ready = 1.
  - A command is never retracted, including when a frame_start arrives for the same port.
  - On the handshake cycle, the next edge sets cmd_valid = 0 and port_grant = one-hot(cmd_port), and the FSM goes to WAIT.
- WAIT:
  - On cmd_done, the next edge sets offset[p] += BURST_LEN, last_grant = p and port_grant = 0, and the FSM goes to ARB.
  - If the new offset equals FRAME_BEATS, port_frame_done[p] is set to 1 on the same edge.
- Minimum spacing: cmd_done to the next cmd_valid is 2 cycles (WAIT->ARB, then ARB->ISSUE).
- cmd_done arriving in ARB or ISSUE is ignored.
- port_frame_start[p] clears offset[p] and port_frame_done[p] on the next edge, in any state.
  - If p is the in-flight port, its completion increment is discarded and the offset stays 0.
  - frame_start has priority over a cmd_done on the same cycle.
- Only one burst is outstanding at any time.
- port_level is sampled only in ARB.
- Exactly one port_grant bit is high, and only during WAIT.

Test Plan:
1. After reset, only port 0 at level 16; cmd_ready = 1 and cmd_done 4 cycles after accept.
   -> cmd_addr 0x1000_0000, cmd_len 15, cmd_rd 0, port_grant 3'b001 during WAIT.
   -> Next command at 0x1000_0100, 2 cycles after cmd_done.
2. All three ports at level 20.
   -> Grant order 0,1,2,0.
   -> Port 1 address 0x1080_0000; port 2 address 0x1100_0000 with cmd_rd 1.
3. cmd_ready held low for 5 cycles in ISSUE.
   -> cmd_valid and fields stable for all 5 cycles; port_grant stays 0 until the handshake.
4. FRAME_BEATS = 64, port 0 permanently at level 16.
   -> After 4 bursts port_frame_done[0] = 1 and no further commands are issued.
   -> A port_frame_start[0] pulse clears the flag; the next cmd_addr is 0x1000_0000.
5. port_frame_start[0] pulsed during WAIT, and separately on the same cycle as cmd_done.
   -> In both cases offset[0] = 0 afterwards; the next port 0 address is 0x1000_0000.
6. Port 0 at level 15 -> no command issued. Then M_AXI_ARESET asserted mid-WAIT -> all outputs 0 on the next edge and the first grant goes to port 0.
